rcservo_bank: RTL and testbench
===============================

// Module: rcservo_bank
// PURPOSE
//   Multi-channel RC-servo pulse generator; parametrised successor to the single-channel servo output.
//   CHANNELS outputs share one prescaler and frame counter. Each output emits one pulse per frame of
//   width MIN_STEPS+position steps. Positions are written by the SPI register decoder into staging
//   registers and applied atomically at frame boundaries.
//   Link-loss failsafe silences outputs when writes stop.
// PARAMETERS
//   CHANNELS        4      number of servo outputs (1..16)
//   AW              2      wr_addr width; 2**AW >= CHANNELS
//   POS_W           8      position width
//   CLK_DIV         98     clk cycles per step (>=2); 25 MHz/1 kHz/256
//   FRAME_W         12     step counter width; frame = 2**FRAME_W steps
//   MIN_STEPS       256    pulse offset in steps (1 ms); MIN_STEPS+2**POS_W-1 < 2**FRAME_W required
//   FAILSAFE_FRAMES 50     frames without a valid write before failsafe; 0 disables failsafe
// PORTS
//   clk          in   1         system clock
//   rst_n        in   1         synchronous reset, active low
//   wr_en        in   1         staging write strobe, one clk per write
//   wr_addr      in   AW        channel index; >= CHANNELS ignored
//   wr_data      in   POS_W     position value
//   ch_enable    in   CHANNELS  per-channel enable, sampled at frame boundary
//   out          out  CHANNELS  servo pulse outputs, registered
//   frame_start  out  1         one-clk pulse on each frame boundary
//   failsafe     out  1         high while link-loss failsafe active
// BEHAVIOUR
//   Reset (rst_n low at posedge clk): prescaler=0, step=0, staging[i]=shadow[i]=2**(POS_W-1), en_shadow=0,
//     silence counter=0, fs_gate=0, out=0, frame_start=0, failsafe=0. Reset mid-pulse: out low next clk.
//   Prescaler: counts 0..CLK_DIV-1 then wraps. tick=1 on the cycle prescaler==CLK_DIV-1.
//   Step counter: FRAME_W bits; +1 on tick; natural wrap 2**FRAME_W-1 -> 0.
//   Frame boundary (fb): tick && step==all-ones.
//     On fb: shadow<=staging, en_shadow<=ch_enable, fs_gate<=failsafe. frame_start registered; high the clk after fb.
//   Write: on wr_en with wr_addr<CHANNELS, staging[wr_addr]<=wr_data. Out-of-range address: no effect,
//     including no effect on the failsafe counter.
//     Write in the fb cycle: shadow loads the pre-write staging value; the new value applies one frame later.
//   Output: out[i] <= en_shadow[i] & ~fs_gate & (step < MIN_STEPS + shadow[i]).
//     Compare at FRAME_W bits, zero-extend shadow. One clk latency from step to out.
//     High-time = (MIN_STEPS+pos)*CLK_DIV clks; period = 2**FRAME_W*CLK_DIV clks.
//     Pulse width stays constant within a frame regardless of writes.
//   Failsafe (FAILSAFE_FRAMES>0):
//     Silence counter: +1 on each fb; saturates at FAILSAFE_FRAMES; cleared by any valid write.
//     Valid write in the same cycle as fb: clear wins.
//     failsafe = (counter==FAILSAFE_FRAMES), registered; drops the clk after a valid write.
//     fs_gate updates only at fb, so outputs never truncate or glitch mid-frame.
//   FAILSAFE_FRAMES==0: counter, failsafe and fs_gate held at 0.
// TESTING (CHANNELS=4, POS_W=4, CLK_DIV=2, FRAME_W=6, MIN_STEPS=16, FAILSAFE_FRAMES=3)
//   1. Reset, ch_enable=4'hF, no writes:
//      -> from the 2nd frame each out high 48 clks / 128-clk period; frame_start every 128 clks.
//   2. Mid-frame write ch0=0, ch1=15:
//      -> current frame unchanged; next frame ch0 high 32 clks, ch1 high 62 clks, ch2/ch3 stay 48.
//   3. Write ch2=4 in the fb cycle:
//      -> following frame still 48 clks; the frame after is 40 clks.
//   4. No writes for 3 frames:
//      -> failsafe rises after the 3rd fb; all out low from the 4th frame.
//      Write ch0=8 -> failsafe low the next clk; pulses resume at the next fb.
//   5. Assert rst_n=0 while out=1:
//      -> out=0 the next clk; after release, positions return to 8 and frame timing restarts from step 0.
//   6. wr_en with wr_addr=3 (valid) vs CHANNELS=3 build wr_addr=3:
//      -> ignored, no staging change, failsafe counter not cleared.

Source files
------------

// File: rtl/rcservo_bank.sv
`default_nettype none
// ============================================================================
// rcservo_bank : multi-channel RC-servo pulse generator with frame-aligned
//                position updates and link-loss failsafe.   Rev 1.0
// ============================================================================
module rcservo_bank #(
  parameter int CHANNELS        = 4,
  parameter int AW              = 2,
  parameter int POS_W           = 8,
  parameter int CLK_DIV         = 98,
  parameter int FRAME_W         = 12,
  parameter int MIN_STEPS       = 256,
  parameter int FAILSAFE_FRAMES = 50
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [POS_W-1:0]    wr_data,
  input  logic [CHANNELS-1:0] ch_enable,
  output logic [CHANNELS-1:0] out,
  output logic                frame_start,
  output logic                failsafe
);

  localparam int                 PW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0]      PRE_LAST = PW'(CLK_DIV - 1);
  localparam logic [AW:0]        CH_LIMIT = (AW+1)'(CHANNELS);
  localparam logic [FRAME_W-1:0] MIN_OFF  = FRAME_W'(MIN_STEPS);
  localparam logic [POS_W-1:0]   POS_MID  = POS_W'(1) << (POS_W - 1);

  logic [PW-1:0]      presc;
  logic [FRAME_W-1:0] step;
  logic [POS_W-1:0]   staging [CHANNELS];
  logic [POS_W-1:0]   shadow  [CHANNELS];
  logic [FRAME_W-1:0] limit   [CHANNELS];
  logic [CHANNELS-1:0] en_shadow;
  logic               fs_gate;
  logic               tick;
  logic               fb;
  logic               wr_valid;

  assign tick     = (presc == PRE_LAST);
  assign fb       = tick && (&step);
  assign wr_valid = wr_en && ({1'b0, wr_addr} < CH_LIMIT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc       <= '0;
      step        <= '0;
      frame_start <= 1'b0;
    end else begin
      presc       <= tick ? '0 : presc + 1'b1;
      if (tick) step <= step + 1'b1;
      frame_start <= fb;
    end
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      limit[i] = MIN_OFF + FRAME_W'(shadow[i]);
    end
  end

  // Non-blocking update: a write in the fb cycle lands in staging after shadow has sampled it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        staging[i] <= POS_MID;
        shadow[i]  <= POS_MID;
      end
      en_shadow <= '0;
      out       <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (fb) shadow[i] <= staging[i];
        if (wr_valid && (wr_addr == AW'(i))) staging[i] <= wr_data;
        out[i] <= en_shadow[i] & ~fs_gate & (step < limit[i]);
      end
      if (fb) en_shadow <= ch_enable;
    end
  end

  if (FAILSAFE_FRAMES > 0) begin : g_failsafe
    localparam int            SW      = $clog2(FAILSAFE_FRAMES + 1);
    localparam logic [SW-1:0] SIL_MAX = SW'(FAILSAFE_FRAMES);

    logic [SW-1:0] silence;
    logic [SW-1:0] silence_nxt;

    always_comb begin
      silence_nxt = silence;
      if (wr_valid) begin
        silence_nxt = '0;
      end else if (fb && (silence != SIL_MAX)) begin
        silence_nxt = silence + 1'b1;
      end
    end

    // failsafe tracks the next counter value so a valid write drops it on the following clk.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        silence  <= '0;
        failsafe <= 1'b0;
        fs_gate  <= 1'b0;
      end else begin
        silence  <= silence_nxt;
        failsafe <= (silence_nxt == SIL_MAX);
        if (fb) fs_gate <= failsafe;
      end
    end
  end else begin : g_no_failsafe
    assign failsafe = 1'b0;
    assign fs_gate  = 1'b0;
  end

endmodule
`default_nettype wire

// File: tb/tb_rcservo_bank.sv
`default_nettype none
// Directed self-checking bench for rcservo_bank (4-channel build, plus a 3-channel build on shared inputs).
module tb_rcservo_bank;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [3:0] wr_data;
  logic [3:0] ch_enable;
  logic [3:0] out;
  logic       frame_start;
  logic       failsafe;
  logic [2:0] out3;
  logic       frame_start3;
  logic       failsafe3;

  int   tests = 0;
  int   fails = 0;
  int   hi  [4];
  int   hi3 [3];
  int   e   [4];
  int   fs_seen;
  logic fs_after;

  always #5 clk = ~clk;

  rcservo_bank #(
    .CHANNELS(4), .AW(2), .POS_W(4), .CLK_DIV(2), .FRAME_W(6), .MIN_STEPS(16), .FAILSAFE_FRAMES(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ch_enable(ch_enable), .out(out), .frame_start(frame_start), .failsafe(failsafe)
  );

  rcservo_bank #(
    .CHANNELS(3), .AW(2), .POS_W(4), .CLK_DIV(2), .FRAME_W(6), .MIN_STEPS(16), .FAILSAFE_FRAMES(3)
  ) dut3 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ch_enable(ch_enable[2:0]), .out(out3), .frame_start(frame_start3), .failsafe(failsafe3)
  );

  // Entered on the negedge where frame_start is high; leaves on the next such negedge.
  task automatic measure_frame(input int wr_at, input int n_wr,
                               input logic [1:0] a0, input logic [3:0] d0,
                               input logic [1:0] a1, input logic [3:0] d1);
    for (int i = 0; i < 4; i++) hi[i] = 0;
    for (int i = 0; i < 3; i++) hi3[i] = 0;
    fs_seen  = 0;
    fs_after = 1'bx;
    for (int k = 0; k < 128; k++) begin
      if (k > 0) @(negedge clk);
      if (wr_at >= 0 && k >= wr_at && k < wr_at + n_wr) begin
        wr_en   = 1'b1;
        wr_addr = (k == wr_at) ? a0 : a1;
        wr_data = (k == wr_at) ? d0 : d1;
      end else begin
        wr_en = 1'b0;
      end
      if (wr_at >= 0 && k == wr_at + n_wr) fs_after = failsafe;
      for (int i = 0; i < 4; i++) hi[i] += int'(out[i]);
      for (int i = 0; i < 3; i++) hi3[i] += int'(out3[i]);
      fs_seen += int'(frame_start);
    end
    @(negedge clk);
    wr_en = 1'b0;
    tests++;
    if (frame_start !== 1'b1) begin
      fails++;
      $display("FAIL period: frame_start=%b after 128 clks, required 1", frame_start);
    end
    tests++;
    if (fs_seen !== 1) begin
      fails++;
      $display("FAIL frame_start_count: %0d pulses in frame, required 1", fs_seen);
    end
  endtask

  task automatic wait_first_frame(input string tag);
    int n;
    int highs;
    n     = 0;
    highs = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      highs += int'(out != 4'h0);
      if (frame_start === 1'b1) break;
    end
    tests++;
    if (n !== 128) begin
      fails++;
      $display("FAIL %s_first_fb: frame_start after %0d clks, required 128", tag, n);
    end
    tests++;
    if (highs !== 0) begin
      fails++;
      $display("FAIL %s_first_frame_silent: %0d clks with out high, required 0", tag, highs);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = 2'd0;
    wr_data   = 4'd0;
    ch_enable = 4'hF;
    repeat (3) @(negedge clk);
    tests++;
    if (out !== 4'h0 || frame_start !== 1'b0 || failsafe !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: out=%h fs=%b failsafe=%b, required 0/0/0", out, frame_start, failsafe);
    end
    rst_n = 1'b1;
    wait_first_frame("reset");
  endtask

  task automatic test_idle_frames();
    measure_frame(-1, 0, 2'd0, 4'd0, 2'd0, 4'd0);
    e = '{48, 48, 48, 48};
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (hi[i] !== e[i]) begin
        fails++;
        $display("FAIL idle_ch%0d: high %0d clks, required %0d", i, hi[i], e[i]);
      end
    end
  endtask

  task automatic test_midframe_write();
    measure_frame(20, 2, 2'd0, 4'd0, 2'd1, 4'd15);
    e = '{48, 48, 48, 48};
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (hi[i] !== e[i]) begin
        fails++;
        $display("FAIL midwrite_same_frame_ch%0d: high %0d clks, required %0d", i, hi[i], e[i]);
      end
    end
    // Next frame carries the new positions; ch2 is written in its last (fb) cycle.
    measure_frame(127, 1, 2'd2, 4'd4, 2'd0, 4'd0);
    e = '{32, 62, 48, 48};
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (hi[i] !== e[i]) begin
        fails++;
        $display("FAIL midwrite_next_frame_ch%0d: high %0d clks, required %0d", i, hi[i], e[i]);
      end
    end
  endtask

  task automatic test_fb_write();
    measure_frame(-1, 0, 2'd0, 4'd0, 2'd0, 4'd0);
    tests++;
    if (hi[2] !== 48) begin
      fails++;
      $display("FAIL fbwrite_following_ch2: high %0d clks, required 48", hi[2]);
    end
    measure_frame(-1, 0, 2'd0, 4'd0, 2'd0, 4'd0);
    tests++;
    if (hi[2] !== 40) begin
      fails++;
      $display("FAIL fbwrite_after_ch2: high %0d clks, required 40", hi[2]);
    end
  endtask

  task automatic test_failsafe();
    tests++;
    if (failsafe !== 1'b0) begin
      fails++;
      $display("FAIL failsafe_early: failsafe=%b, required 0", failsafe);
    end
    measure_frame(-1, 0, 2'd0, 4'd0, 2'd0, 4'd0);
    tests++;
    if (failsafe !== 1'b1) begin
      fails++;
      $display("FAIL failsafe_rise: failsafe=%b, required 1", failsafe);
    end
    measure_frame(-1, 0, 2'd0, 4'd0, 2'd0, 4'd0);
    e = '{32, 62, 40, 48};
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (hi[i] !== e[i]) begin
        fails++;
        $display("FAIL failsafe_no_truncate_ch%0d: high %0d clks, required %0d", i, hi[i], e[i]);
      end
    end
    measure_frame(-1, 0, 2'd0, 4'd0, 2'd0, 4'd0);
    tests++;
    if (hi[0] + hi[1] + hi[2] + hi[3] !== 0) begin
      fails++;
      $display("FAIL failsafe_silent: %0d/%0d/%0d/%0d clks high, required 0", hi[0], hi[1], hi[2], hi[3]);
    end
    measure_frame(10, 1, 2'd0, 4'd8, 2'd0, 4'd0);
    tests++;
    if (fs_after !== 1'b0) begin
      fails++;
      $display("FAIL failsafe_drop: failsafe=%b the clk after write, required 0", fs_after);
    end
    tests++;
    if (hi[0] + hi[1] + hi[2] + hi[3] !== 0) begin
      fails++;
      $display("FAIL failsafe_hold_to_fb: %0d clks high total, required 0", hi[0] + hi[1] + hi[2] + hi[3]);
    end
    measure_frame(-1, 0, 2'd0, 4'd0, 2'd0, 4'd0);
    e = '{48, 62, 40, 48};
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (hi[i] !== e[i]) begin
        fails++;
        $display("FAIL failsafe_resume_ch%0d: high %0d clks, required %0d", i, hi[i], e[i]);
      end
    end
  endtask

  task automatic test_reset_midpulse();
    repeat (5) @(negedge clk);
    tests++;
    if (out !== 4'hF) begin
      fails++;
      $display("FAIL midpulse_precondition: out=%h, required f", out);
    end
    rst_n = 1'b0;
    @(negedge clk);
    tests++;
    if (out !== 4'h0 || frame_start !== 1'b0 || failsafe !== 1'b0) begin
      fails++;
      $display("FAIL midpulse_reset: out=%h fs=%b failsafe=%b, required 0/0/0", out, frame_start, failsafe);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_first_frame("midpulse");
  endtask

  task automatic test_oor_write();
    measure_frame(30, 1, 2'd3, 4'd0, 2'd0, 4'd0);
    e = '{48, 48, 48, 48};
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (hi[i] !== e[i]) begin
        fails++;
        $display("FAIL reset_positions_ch%0d: high %0d clks, required %0d", i, hi[i], e[i]);
      end
    end
    measure_frame(30, 1, 2'd3, 4'd0, 2'd0, 4'd0);
    e = '{48, 48, 48, 32};
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (hi[i] !== e[i]) begin
        fails++;
        $display("FAIL addr3_valid_ch%0d: high %0d clks, required %0d", i, hi[i], e[i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (hi3[i] !== 48) begin
        fails++;
        $display("FAIL addr3_ignored_ch%0d: high %0d clks, required 48", i, hi3[i]);
      end
    end
    tests++;
    if (failsafe3 !== 1'b1 || frame_start3 !== 1'b1) begin
      fails++;
      $display("FAIL addr3_no_clear: failsafe3=%b frame_start3=%b, required 1/1", failsafe3, frame_start3);
    end
    tests++;
    if (failsafe !== 1'b0) begin
      fails++;
      $display("FAIL addr3_clears_4ch: failsafe=%b, required 0", failsafe);
    end
  endtask

  initial begin
    test_reset();
    test_idle_frames();
    test_midframe_write();
    test_fb_write();
    test_failsafe();
    test_reset_midpulse();
    test_oor_write();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
